// File: rtl/machine_ram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : machine_ram_arbiter                                          |
// | Description : Two-port round-robin arbiter with bounded locking in front   |
// |               of the 80 x 64 Machine block RAM; routes 1-cycle read data   |
// |               back to the issuing port. Optional macro                     |
// |               MACHINE_RAM_ARB_STATS_EN adds grant/conflict counters.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module machine_ram_arbiter #(
    parameter int DEPTH    = 80,
    parameter int ADDR_W   = 30,
    parameter int DATA_W   = 64,
    parameter int LOCK_MAX = 4
) (
    input  logic              system1000,
    input  logic              system1000_rst,
    input  logic              p0_valid,
    output logic              p0_ready,
    input  logic              p0_we,
    input  logic              p0_lock,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_rsp_valid,
    output logic              p0_rsp_err,
    output logic [DATA_W-1:0] p0_rsp_data,
    input  logic              p1_valid,
    output logic              p1_ready,
    input  logic              p1_we,
    input  logic              p1_lock,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_rsp_valid,
    output logic              p1_rsp_err,
    output logic [DATA_W-1:0] p1_rsp_data,
`ifdef MACHINE_RAM_ARB_STATS_EN
    output logic [31:0]       stat_grants0,
    output logic [31:0]       stat_grants1,
    output logic [31:0]       stat_conflicts,
`endif
    output logic [ADDR_W-1:0] ram_raddr,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int c_CNT_W = $clog2(LOCK_MAX + 1);

    logic               r_rr_ptr;
    logic               r_lock_active;
    logic               r_lock_owner;
    logic [c_CNT_W-1:0] r_lock_cnt;
    logic               r_tag_valid;
    logic               r_tag_port;
    logic               r_tag_err;
    logic [ADDR_W-1:0]  r_raddr;

    logic               w_any;
    logic               w_gnt;
    logic               w_sel_we;
    logic               w_sel_lock;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_wdata;
    logic               w_in_range;
    logic               w_rd;
    logic               w_wr;
    logic [c_CNT_W-1:0] w_run;
    logic               w_rsp_ok;

    // Nothing is accepted while reset is held, so reset leaves no side effects.
    always_comb begin
        w_any = (p0_valid | p1_valid) & ~system1000_rst;
        if (p0_valid & p1_valid) begin
            w_gnt = r_lock_active ? r_lock_owner : r_rr_ptr;
        end else begin
            w_gnt = p1_valid;
        end
        w_sel_we    = w_gnt ? p1_we    : p0_we;
        w_sel_lock  = w_gnt ? p1_lock  : p0_lock;
        w_sel_addr  = w_gnt ? p1_addr  : p0_addr;
        w_sel_wdata = w_gnt ? p1_wdata : p0_wdata;
        w_in_range  = (w_sel_addr < ADDR_W'(DEPTH));
        w_rd        = w_any & ~w_sel_we;
        w_wr        = w_any & w_sel_we;
        // Length of the locked run including this grant.
        if (r_lock_active && (r_lock_owner == w_gnt)) begin
            w_run = r_lock_cnt + c_CNT_W'(1);
        end else begin
            w_run = c_CNT_W'(1);
        end
    end

    assign p0_ready  = w_any & ~w_gnt & p0_valid;
    assign p1_ready  = w_any &  w_gnt & p1_valid;
    assign ram_we    = w_wr & w_in_range;
    assign ram_waddr = w_sel_addr;
    assign ram_wdata = w_sel_wdata;
    assign ram_raddr = w_rd ? w_sel_addr : r_raddr;

    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            r_rr_ptr      <= 1'b0;
            r_lock_active <= 1'b0;
            r_lock_owner  <= 1'b0;
            r_lock_cnt    <= '0;
            r_tag_valid   <= 1'b0;
            r_tag_port    <= 1'b0;
            r_tag_err     <= 1'b0;
            r_raddr       <= '0;
        end else begin
            if (w_any) begin
                r_rr_ptr <= ~w_gnt;
            end
            // Reaching LOCK_MAX drops the lock; rr_ptr already favours the other port.
            if (w_any && w_sel_lock && (w_run < c_CNT_W'(LOCK_MAX))) begin
                r_lock_active <= 1'b1;
                r_lock_owner  <= w_gnt;
                r_lock_cnt    <= w_run;
            end else begin
                r_lock_active <= 1'b0;
                r_lock_cnt    <= '0;
            end
            r_tag_valid <= w_rd;
            r_tag_port  <= w_gnt;
            r_tag_err   <= ~w_in_range;
            if (w_rd) begin
                r_raddr <= w_sel_addr;
            end
        end
    end

    // A tag in flight when reset arrives never surfaces as a response.
    assign w_rsp_ok     = r_tag_valid & ~r_tag_err & ~system1000_rst;
    assign p0_rsp_valid = r_tag_valid & ~r_tag_port & ~system1000_rst;
    assign p1_rsp_valid = r_tag_valid &  r_tag_port & ~system1000_rst;
    assign p0_rsp_err   = p0_rsp_valid & r_tag_err;
    assign p1_rsp_err   = p1_rsp_valid & r_tag_err;
    assign p0_rsp_data  = (w_rsp_ok & ~r_tag_port) ? ram_rdata : '0;
    assign p1_rsp_data  = (w_rsp_ok &  r_tag_port) ? ram_rdata : '0;

`ifdef MACHINE_RAM_ARB_STATS_EN
    logic [31:0] r_stat_grants0;
    logic [31:0] r_stat_grants1;
    logic [31:0] r_stat_conflicts;

    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            r_stat_grants0   <= '0;
            r_stat_grants1   <= '0;
            r_stat_conflicts <= '0;
        end else begin
            if (w_any && !w_gnt && (r_stat_grants0 != '1)) begin
                r_stat_grants0 <= r_stat_grants0 + 32'd1;
            end
            if (w_any && w_gnt && (r_stat_grants1 != '1)) begin
                r_stat_grants1 <= r_stat_grants1 + 32'd1;
            end
            if (p0_valid && p1_valid && (r_stat_conflicts != '1)) begin
                r_stat_conflicts <= r_stat_conflicts + 32'd1;
            end
        end
    end

    assign stat_grants0   = r_stat_grants0;
    assign stat_grants1   = r_stat_grants1;
    assign stat_conflicts = r_stat_conflicts;
`endif

endmodule
`default_nettype wire

// File: tb/tb_machine_ram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_machine_ram_arbiter                                       |
// | Description : Directed plus randomized bench for machine_ram_arbiter       |
// |               against a transaction-level reference model and RAM shadow.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_machine_ram_arbiter;

    localparam int DEPTH    = 80;
    localparam int ADDR_W   = 30;
    localparam int DATA_W   = 64;
    localparam int LOCK_MAX = 4;

    logic              system1000 = 1'b0;
    logic              system1000_rst;
    logic              p0_valid, p0_we, p0_lock, p1_valid, p1_we, p1_lock;
    logic              p0_ready, p1_ready;
    logic [ADDR_W-1:0] p0_addr, p1_addr;
    logic [DATA_W-1:0] p0_wdata, p1_wdata;
    logic              p0_rsp_valid, p0_rsp_err, p1_rsp_valid, p1_rsp_err;
    logic [DATA_W-1:0] p0_rsp_data, p1_rsp_data;
    logic [ADDR_W-1:0] ram_raddr, ram_waddr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata, ram_rdata;
`ifdef MACHINE_RAM_ARB_STATS_EN
    logic [31:0]       stat_grants0, stat_grants1, stat_conflicts;
`endif

    always #5 system1000 = ~system1000;

    machine_ram_arbiter #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOCK_MAX(LOCK_MAX)
    ) dut (
        .system1000(system1000), .system1000_rst(system1000_rst),
        .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we), .p0_lock(p0_lock),
        .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_rsp_valid(p0_rsp_valid),
        .p0_rsp_err(p0_rsp_err), .p0_rsp_data(p0_rsp_data),
        .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we), .p1_lock(p1_lock),
        .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_rsp_valid(p1_rsp_valid),
        .p1_rsp_err(p1_rsp_err), .p1_rsp_data(p1_rsp_data),
`ifdef MACHINE_RAM_ARB_STATS_EN
        .stat_grants0(stat_grants0), .stat_grants1(stat_grants1),
        .stat_conflicts(stat_conflicts),
`endif
        .ram_raddr(ram_raddr), .ram_we(ram_we), .ram_waddr(ram_waddr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // Behavioural Machine RAM: write commits at the edge, read data registered.
    logic [DATA_W-1:0] ram_mem [0:DEPTH-1];
    always @(posedge system1000) begin
        if (ram_we && (ram_waddr < 30'(DEPTH))) ram_mem[ram_waddr] <= ram_wdata;
        ram_rdata <= (ram_raddr < 30'(DEPTH)) ? ram_mem[ram_raddr] : 64'hBAD0_BAD0_BAD0_BAD0;
    end

    int total = 0;
    int bad   = 0;

    // Reference model: priority port, current locked run, expected next response.
    logic [DATA_W-1:0] exp_mem [0:DEPTH-1];
    int                m_pri, m_owner, m_run;
    logic [ADDR_W-1:0] m_last_raddr;
    bit                e_valid, e_err;
    int                e_port;
    logic [DATA_W-1:0] e_data;
    int                obs_seq[$];
    int                obs_rsp0, obs_rsp1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pri = 0; m_owner = -1; m_run = 0; m_last_raddr = '0;
        e_valid = 0; e_err = 0; e_port = 0; e_data = '0;
    endtask

    task automatic cycle(input bit rst,
                         input bit v0, input bit we0, input bit lk0,
                         input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                         input bit v1, input bit we1, input bit lk1,
                         input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1);
        int g;
        bit acc, we, lk, inr;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        @(posedge system1000);
        #1;
        system1000_rst = rst;
        p0_valid = v0; p0_we = we0; p0_lock = lk0; p0_addr = a0; p0_wdata = d0;
        p1_valid = v1; p1_we = we1; p1_lock = lk1; p1_addr = a1; p1_wdata = d1;
        #4;
        acc = !rst && (v0 || v1);
        if (v0 && v1) g = (m_owner >= 0) ? m_owner : m_pri;
        else          g = v1 ? 1 : 0;
        we  = (g == 1) ? we1 : we0;
        lk  = (g == 1) ? lk1 : lk0;
        a   = (g == 1) ? a1  : a0;
        d   = (g == 1) ? d1  : d0;
        inr = (a < 30'(DEPTH));

        check("p0_ready", p0_ready, acc && g == 0);
        check("p1_ready", p1_ready, acc && g == 1);
        check("ram_we",   ram_we,   acc && we && inr);
        if (acc && we && inr) begin
            check("ram_waddr", ram_waddr, a);
            check("ram_wdata", ram_wdata, d);
        end
        check("ram_raddr", ram_raddr, (acc && !we) ? a : m_last_raddr);
        check("p0_rsp_valid", p0_rsp_valid, !rst && e_valid && e_port == 0);
        check("p1_rsp_valid", p1_rsp_valid, !rst && e_valid && e_port == 1);
        check("p0_rsp_err",   p0_rsp_err,   !rst && e_valid && e_port == 0 && e_err);
        check("p1_rsp_err",   p1_rsp_err,   !rst && e_valid && e_port == 1 && e_err);
        check("p0_rsp_data",  p0_rsp_data,  (!rst && e_valid && e_port == 0 && !e_err) ? e_data : 64'd0);
        check("p1_rsp_data",  p1_rsp_data,  (!rst && e_valid && e_port == 1 && !e_err) ? e_data : 64'd0);

        if (p0_ready) obs_seq.push_back(0);
        if (p1_ready) obs_seq.push_back(1);
        obs_rsp0 += int'(p0_rsp_valid);
        obs_rsp1 += int'(p1_rsp_valid);

        if (rst) begin
            model_reset();
        end else begin
            e_valid = acc && !we;
            e_port  = g;
            e_err   = !inr;
            e_data  = inr ? exp_mem[a] : 64'd0;
            if (acc && !we) m_last_raddr = a;
            if (acc && we && inr) exp_mem[a] = d;
            if (acc) begin
                m_pri = 1 - g;
                if (lk) begin
                    m_run = (m_owner == g) ? m_run + 1 : 1;
                    if (m_run >= LOCK_MAX) begin
                        m_owner = -1; m_run = 0;
                    end else begin
                        m_owner = g;
                    end
                end else begin
                    m_owner = -1; m_run = 0;
                end
            end else begin
                m_owner = -1; m_run = 0;
            end
        end
    endtask

    task automatic idle(input bit rst);
        cycle(rst, 0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
    endtask

    task automatic do_reset();
        idle(1);
        idle(1);
        obs_seq.delete();
        obs_rsp0 = 0;
        obs_rsp1 = 0;
    endtask

    initial begin
        int nmis;
        system1000_rst = 1'b1;
        p0_valid = 0; p0_we = 0; p0_lock = 0; p0_addr = '0; p0_wdata = '0;
        p1_valid = 0; p1_we = 0; p1_lock = 0; p1_addr = '0; p1_wdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ram_mem[i] = {32'hA5A5_0000 + 32'(i), 32'(i) * 32'h0101_0101};
            exp_mem[i] = {32'hA5A5_0000 + 32'(i), 32'(i) * 32'h0101_0101};
        end
        model_reset();
        obs_rsp0 = 0;
        obs_rsp1 = 0;

        // Reset state, then idle outputs
        do_reset();
        idle(0);

        // Write then read back on port 0
        cycle(0, 1, 1, 0, 30'd5, 64'h1122334455667788, 0, 0, 0, '0, '0);
        cycle(0, 1, 0, 0, 30'd5, '0,                    0, 0, 0, '0, '0);
        idle(0);
        check("wr_rd_data", p0_rsp_data, 64'h1122334455667788);

        // Contention from reset: six cycles of both ports reading
        do_reset();
        for (int i = 0; i < 6; i++) cycle(0, 1, 0, 0, 30'd0, '0, 1, 0, 0, 30'd1, '0);
        idle(0);
        for (int i = 0; i < 6; i++) check("contention_seq", obs_seq.size() > i ? obs_seq[i] : -1, i % 2);
        check("contention_rsp0", obs_rsp0, 3);
        check("contention_rsp1", obs_rsp1, 3);
`ifdef MACHINE_RAM_ARB_STATS_EN
        check("stat_grants0",   stat_grants0,   3);
        check("stat_grants1",   stat_grants1,   3);
        check("stat_conflicts", stat_conflicts, 6);
`endif

        // Lock limit: p1 takes the lock, then holds it against p0
        do_reset();
        cycle(0, 0, 0, 0, 30'd2, '0, 1, 0, 1, 30'd3, '0);
        for (int i = 0; i < 6; i++) cycle(0, 1, 0, 0, 30'd2, '0, 1, 0, 1, 30'd3, '0);
        idle(0);
        for (int i = 0; i < 6; i++)
            check("lock_seq", obs_seq.size() > i ? obs_seq[i] : -1, (i == 4) ? 0 : 1);

        // Out-of-range read on p0, dropped write on p1
        cycle(0, 1, 0, 0, 30'd80, '0, 0, 0, 0, '0, '0);
        idle(0);
        check("oor_rsp_err",  p0_rsp_err,  1);
        check("oor_rsp_data", p0_rsp_data, 0);
        cycle(0, 0, 0, 0, '0, '0, 1, 1, 0, 30'd100, 64'hDEAD_BEEF_DEAD_BEEF);
        idle(0);

        // Reset the cycle after a read is accepted
        cycle(0, 1, 0, 0, 30'd7, '0, 0, 0, 0, '0, '0);
        idle(1);
        idle(0);
        check("post_rst_raddr", ram_raddr, 0);

        // Randomized traffic, including occasional resets
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 99) == 0),
                  1'($urandom), 1'($urandom_range(0, 2) == 0), 1'($urandom),
                  30'($urandom_range(0, 95)), {$urandom, $urandom},
                  1'($urandom), 1'($urandom_range(0, 2) == 0), 1'($urandom),
                  30'($urandom_range(0, 95)), {$urandom, $urandom});
        end
        idle(0);
        idle(0);

        nmis = 0;
        for (int i = 0; i < DEPTH; i++) if (ram_mem[i] !== exp_mem[i]) nmis++;
        check("ram_contents", nmis, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/machine_ram_arbiter.md
Name: machine_ram_arbiter

Overview:
- Two-port arbiter that shares the single Machine block RAM (80 x 64-bit, 1-cycle registered read, one write per cycle) between two requesters, e.g. core data port (port 0) and program loader / debug port (port 1).
- Performs round-robin arbitration with optional short-term locking, and routes 1-cycle-latency read data back to the issuing port with a response tag.
- Drives the RAM's read address, write enable, write address and write data.

Parameters:
- DEPTH, 80, number of RAM words; addresses >= DEPTH are out of range.
- ADDR_W, 30, requester/RAM address width (matches the RAM's 30-bit address fields).
- DATA_W, 64, data word width.
- LOCK_MAX, 4, maximum consecutive grants a locking port may hold before being forced to yield.

Ports:
- system1000  in  1  clock
- system1000_rst  in  1  synchronous reset, active-high
- p0_valid / p1_valid  in  1  request valid
- p0_ready / p1_ready  out  1  request accepted this cycle (combinational grant)
- p0_we / p1_we  in  1  1 = write, 0 = read
- p0_lock / p1_lock  in  1  request priority retention on next cycle
- p0_addr / p1_addr  in  ADDR_W  word address
- p0_wdata / p1_wdata  in  DATA_W  write data
- p0_rsp_valid / p1_rsp_valid  out  1  read response valid
- p0_rsp_err / p1_rsp_err  out  1  response is for an out-of-range read
- p0_rsp_data / p1_rsp_data  out  DATA_W  read data
- ram_raddr  out  ADDR_W  RAM read address
- ram_we  out  1  RAM write enable
- ram_waddr  out  ADDR_W  RAM write address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM registered read data, valid the cycle after ram_raddr

Behaviour:
- Reset values:
  - rr_ptr = 0: port 0 has priority.
  - Lock state cleared; lock_cnt = 0.
  - Response pipeline tag invalid.
  - All rsp_valid/rsp_err = 0, rsp_data = 0.
  - ram_we = 0, ram_raddr = 0.
- Arbitration, at most one accept per cycle:
  - Only one port valid: that port is granted.
  - Both valid: lock owner wins if lock is active; otherwise the port selected by rr_ptr wins.
  - After each accept, rr_ptr points to the non-granted port.
  - pX_ready = grant & pX_valid. There is no ready without valid.
- Lock:
  - An accepted request with pX_lock = 1 makes that port lock owner for the next cycle and increments lock_cnt.
  - Lock clears on any of: an accept with lock = 0, owner valid dropping, or lock_cnt reaching LOCK_MAX. On the LOCK_MAX case the other port gets priority next cycle if valid.
  - lock_cnt resets to 0 whenever the lock clears.
- Accepted write, in range:
  - ram_we = 1, ram_waddr = addr, ram_wdata = wdata in the same cycle (combinational pass-through).
  - No response is generated.
- Accepted write, out of range (addr >= DEPTH): ram_we stays 0; the write is silently dropped.
- Accepted read:
  - ram_raddr = addr in the same cycle.
  - A registered tag {valid, port, err} captures the issuing port and err = (addr >= DEPTH).
  - Next cycle the tagged port sees rsp_valid = 1 and rsp_data = ram_rdata, or rsp_data = 0 with rsp_err = 1 if err.
  - Response is pulsed for exactly one cycle; no backpressure on responses.
  - Back-to-back reads are sustained at 1 per cycle.
- Idle cycle: ram_raddr holds its last value and ram_we = 0.
- Write then read of the same address on consecutive cycles: the read returns the new data, because the RAM write commits at the edge before the read is sampled.
- Reset mid-operation: an in-flight read tag is discarded; no response is issued after reset.

Optional Feature:
- Macro: MACHINE_RAM_ARB_STATS_EN.
- Defined: adds outputs stat_grants0, stat_grants1 (32-bit accept counters per port) and stat_conflicts (32-bit, counts cycles where both ports were valid).
  - All three are cleared by reset and saturate at all-ones.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Write and read back on port 0: p0 write addr 5 data 0x1122334455667788; next cycle p0 read addr 5 -> p0_rsp_valid one cycle later with data 0x1122334455667788 and err 0.
- Contention: both ports issue reads of addr 0 and 1 every cycle for 6 cycles from reset -> grants alternate p0, p1, p0, ...; each port receives 3 responses, routed to the correct port.
- Lock limit: p1 asserts valid + lock continuously while p0 is valid -> p1 is granted 4 consecutive times (LOCK_MAX), then p0 is granted, then round-robin resumes.
- Out-of-range access: p0 reads addr 80 -> rsp_err = 1 and data 0. p1 writes addr 100 -> ram_we stays 0 and the RAM contents are unchanged.
- Reset mid-read: assert system1000_rst the cycle after a read is accepted -> no rsp_valid on either port, and all outputs are at reset values.
- With MACHINE_RAM_ARB_STATS_EN defined, after the contention scenario: stat_grants0 = 3, stat_grants1 = 3, stat_conflicts = 6.
